// File: rtl/wb_decompressor_pkg.sv
// Shared definitions for the CW <-> Wishbone bridge pair (wb_decompressor and
// wb_compressor): bus widths, the bit layout of header word H0 and the FSM
// state encoding.
package wb_decompressor_pkg;

  localparam int WB_ADDR_W = 24;
  localparam int RW        = 16;

  // H0 header layout; bits [10:8] are reserved and ignored.
  localparam int H0_WE     = 15;
  localparam int H0_B8     = 14;
  localparam int H0_B4     = 13;
  localparam int H0_SEL_HI = 12;
  localparam int H0_SEL_LO = 11;
  localparam int H0_ADR_HI = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADR  = 3'd1,
    WDAT = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4,
    REL  = 3'd5
  } state_e;

  // Beats still to run after the first one: 7 for burst8, 3 for burst4, 0 otherwise.
  function automatic logic [2:0] beats_left(input logic b8, input logic b4);
    if (b8)      return 3'd7;
    else if (b4) return 3'd3;
    else         return 3'd0;
  endfunction

endpackage

// File: rtl/wb_decompressor.sv
// wb_decompressor: CW bus responder that decodes a two-word header (H0/H1),
// optionally collects write data, and replays the access as a single, 4-beat
// or 8-beat Wishbone master transaction.
//
// Ports
//   i_clk, i_rst          clock (shared with the CW initiator), async active-high reset
//   cw_io_i / cw_io_o     CW data in / registered read data out
//   cw_io_oe              registered output enable (cw_dir and an active read)
//   cw_req, cw_dir        CW request, direction (1 = responder drives)
//   cw_ack, cw_err        one-cycle completion / error pulses
//   wb_*                  Wishbone master (cyc/stb/we/adr/sel/dat, ack/err in,
//                         burst-length flags out)
module wb_decompressor
  import wb_decompressor_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [RW-1:0]        cw_io_i,
  output logic [RW-1:0]        cw_io_o,
  output logic                 cw_io_oe,
  input  logic                 cw_req,
  input  logic                 cw_dir,
  output logic                 cw_ack,
  output logic                 cw_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [WB_ADDR_W-1:0] wb_adr,
  output logic [1:0]           wb_sel,
  output logic [RW-1:0]        wb_o_dat,
  input  logic [RW-1:0]        wb_i_dat,
  input  logic                 wb_ack,
  input  logic                 wb_err,
  output logic                 wb_4_burst,
  output logic                 wb_8_burst
);

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic                 b4_q, b4_d;
  logic                 b8_q, b8_d;
  logic [1:0]           sel_q, sel_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [RW-1:0]        wdat_q, wdat_d;
  logic [RW-1:0]        rdat_q, rdat_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    b4_d    = b4_q;
    b8_d    = b8_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (cw_req) begin
          we_d              = cw_io_i[H0_WE];
          b8_d              = cw_io_i[H0_B8];
          b4_d              = cw_io_i[H0_B4];
          sel_d             = cw_io_i[H0_SEL_HI:H0_SEL_LO];
          adr_d[23:16]      = cw_io_i[H0_ADR_HI:0];
          cnt_d             = beats_left(cw_io_i[H0_B8], cw_io_i[H0_B4]);
          state_d           = ADR;
        end
      end
      ADR: begin
        adr_d[15:0] = cw_io_i;
        if (b8_q && b4_q) begin
          // Contradictory burst request: reject without touching Wishbone.
          err_d   = 1'b1;
          state_d = REL;
        end else if (we_q) begin
          state_d = WDAT;
        end else begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end
      WDAT: begin
        wdat_d  = cw_io_i;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = BUS;
      end
      BUS: begin
        // wb_err wins over a simultaneous wb_ack.
        if (wb_err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = REL;
        end else if (wb_ack) begin
          stb_d = 1'b0;
          ack_d = 1'b1;
          if (!we_q) rdat_d = wb_i_dat;
          state_d = RESP;
        end
      end
      RESP: begin
        if (cnt_q == 3'd0) begin
          cyc_d   = 1'b0;
          state_d = REL;
        end else begin
          cnt_d = cnt_q - 3'd1;
          adr_d = adr_q + WB_ADDR_W'(1);
          if (we_q) begin
            state_d = WDAT;
          end else begin
            stb_d   = 1'b1;
            state_d = BUS;
          end
        end
      end
      REL: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        // Wait for the initiator to release cw_req so a held request is
        // never mistaken for a fresh header.
        if (!cw_req) state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Initiator withdrew mid-transaction: silent abort back to IDLE.
    if (!cw_req && state_q != IDLE && state_q != REL) begin
      state_d = IDLE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdat_d  = rdat_q;
    end

    oe_d = cw_dir && !we_d && (state_d inside {ADR, WDAT, BUS, RESP});
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      b4_q    <= 1'b0;
      b8_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      b4_q    <= b4_d;
      b8_q    <= b8_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
    end
  end

  assign cw_io_o    = rdat_q;
  assign cw_io_oe   = oe_q;
  assign cw_ack     = ack_q;
  assign cw_err     = err_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = stb_q;
  assign wb_we      = we_q;
  assign wb_adr     = adr_q;
  assign wb_sel     = sel_q;
  assign wb_o_dat   = wdat_q;
  assign wb_4_burst = b4_q;
  assign wb_8_burst = b8_q;

endmodule

// File: tb/tb_wb_decompressor.sv
// Self-checking bench for wb_decompressor: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_wb_decompressor;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] cw_io_i;
  logic [15:0] cw_io_o;
  logic        cw_io_oe;
  logic        cw_req;
  logic        cw_dir;
  logic        cw_ack;
  logic        cw_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [23:0] wb_adr;
  logic [1:0]  wb_sel;
  logic [15:0] wb_o_dat;
  logic [15:0] wb_i_dat;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_4_burst;
  logic        wb_8_burst;

  int          checks;
  int          errors;
  logic [15:0] last_read;

  wb_decompressor dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .cw_io_i    (cw_io_i),
    .cw_io_o    (cw_io_o),
    .cw_io_oe   (cw_io_oe),
    .cw_req     (cw_req),
    .cw_dir     (cw_dir),
    .cw_ack     (cw_ack),
    .cw_err     (cw_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_o_dat   (wb_o_dat),
    .wb_i_dat   (wb_i_dat),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_4_burst (wb_4_burst),
    .wb_8_burst (wb_8_burst)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(negedge i_clk);
  endtask

  // One complete CW transaction; expectations come from the header fields:
  // beats = 8 / 4 / 1, address = ({H0[7:0],H1} + k) mod 2^24, err_beat < 0 = none.
  task automatic run_txn(input string name, input logic [15:0] h0, input logic [15:0] h1,
                         input logic dir, input int err_beat, input logic [15:0] wbase,
                         input logic [15:0] rbase, input int max_lat);
    logic        we, b8, b4;
    logic [1:0]  sel;
    int          n, base, lat;
    logic [15:0] wd, rd;
    logic [23:0] ea;
    logic        exp_oe;
    we = h0[15]; b8 = h0[14]; b4 = h0[13]; sel = h0[12:11];
    base = int'({h0[7:0], h1});
    n = (b8 && b4) ? 0 : (b8 ? 8 : (b4 ? 4 : 1));
    exp_oe = dir & ~we;

    cw_dir = dir; cw_req = 1'b1; cw_io_i = h0;
    step();
    checks++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b0)
      begin errors++; $display("FAIL %s adr_phase: cyc/stb got %b%b want 00", name, wb_cyc, wb_stb); end
    cw_io_i = h1;
    step();
    if (n == 0) begin
      checks++;
      if (cw_err !== 1'b1 || cw_ack !== 1'b0)
        begin errors++; $display("FAIL %s bad_burst: err/ack got %b%b want 10", name, cw_err, cw_ack); end
      checks++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0)
        begin errors++; $display("FAIL %s bad_burst_bus: cyc/stb got %b%b want 00", name, wb_cyc, wb_stb); end
    end
    for (int k = 0; k < n; k++) begin
      wd = wbase ^ 16'(k * 257);
      rd = rbase + 16'(k);
      ea = 24'((base + k) % 16777216);
      if (we) begin
        checks++;
        if (wb_stb !== 1'b0)
          begin errors++; $display("FAIL %s wdat_stb beat %0d: got %b want 0", name, k, wb_stb); end
        cw_io_i = wd;
        step();
      end
      checks++;
      if (wb_cyc !== 1'b1 || wb_stb !== 1'b1)
        begin errors++; $display("FAIL %s bus_cycstb beat %0d: got %b%b want 11", name, k, wb_cyc, wb_stb); end
      checks++;
      if (wb_adr !== ea)
        begin errors++; $display("FAIL %s adr beat %0d: got %h want %h", name, k, wb_adr, ea); end
      checks++;
      if (wb_we !== we || wb_sel !== sel || wb_4_burst !== b4 || wb_8_burst !== b8)
        begin errors++; $display("FAIL %s ctl beat %0d: got we%b sel%b b4%b b8%b want we%b sel%b b4%b b8%b",
                                 name, k, wb_we, wb_sel, wb_4_burst, wb_8_burst, we, sel, b4, b8); end
      if (we) begin
        checks++;
        if (wb_o_dat !== wd)
          begin errors++; $display("FAIL %s wdata beat %0d: got %h want %h", name, k, wb_o_dat, wd); end
      end
      checks++;
      if (cw_io_oe !== exp_oe)
        begin errors++; $display("FAIL %s oe_bus beat %0d: got %b want %b", name, k, cw_io_oe, exp_oe); end
      lat = int'($urandom_range(max_lat, 0));
      for (int w = 0; w < lat; w++) begin
        wb_i_dat = 16'($urandom);
        step();
        checks++;
        if (wb_stb !== 1'b1 || cw_ack !== 1'b0)
          begin errors++; $display("FAIL %s wait beat %0d: stb/ack got %b%b want 10", name, k, wb_stb, cw_ack); end
      end
      if (k == err_beat) begin
        wb_err = 1'b1; wb_ack = 1'($urandom_range(1, 0));
        step();
        wb_err = 1'b0; wb_ack = 1'b0;
        checks++;
        if (cw_err !== 1'b1 || cw_ack !== 1'b0)
          begin errors++; $display("FAIL %s wb_err_resp: err/ack got %b%b want 10", name, cw_err, cw_ack); end
        checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0)
          begin errors++; $display("FAIL %s wb_err_drop: cyc/stb got %b%b want 00", name, wb_cyc, wb_stb); end
        break;
      end
      wb_ack = 1'b1; wb_i_dat = rd;
      step();
      wb_ack = 1'b0; wb_i_dat = 16'($urandom);
      if (!we) last_read = rd;
      checks++;
      if (cw_ack !== 1'b1 || cw_err !== 1'b0)
        begin errors++; $display("FAIL %s resp beat %0d: ack/err got %b%b want 10", name, k, cw_ack, cw_err); end
      checks++;
      if (wb_stb !== 1'b0 || wb_cyc !== 1'b1)
        begin errors++; $display("FAIL %s resp_bus beat %0d: cyc/stb got %b%b want 10", name, k, wb_cyc, wb_stb); end
      checks++;
      if (cw_io_o !== last_read)
        begin errors++; $display("FAIL %s rdata beat %0d: got %h want %h", name, k, cw_io_o, last_read); end
      checks++;
      if (cw_io_oe !== exp_oe)
        begin errors++; $display("FAIL %s oe_resp beat %0d: got %b want %b", name, k, cw_io_oe, exp_oe); end
      step();
      if (k == n - 1) begin
        checks++;
        if (wb_cyc !== 1'b0 || cw_ack !== 1'b0 || cw_err !== 1'b0)
          begin errors++; $display("FAIL %s end: cyc/ack/err got %b%b%b want 000", name, wb_cyc, cw_ack, cw_err); end
      end
    end
    // Keep cw_req high with a plausible header on the bus: must not restart.
    cw_io_i = 16'h9812;
    for (int h = 0; h < 3; h++) begin
      step();
      checks++;
      if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || cw_ack !== 1'b0 || cw_err !== 1'b0 || cw_io_oe !== 1'b0)
        begin errors++; $display("FAIL %s rel_hold: cyc%b stb%b ack%b err%b oe%b want all 0",
                                 name, wb_cyc, wb_stb, cw_ack, cw_err, cw_io_oe); end
    end
    cw_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; cw_req = 1'b0; cw_dir = 1'b0; cw_io_i = 16'h0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_i_dat = 16'h0;
    step(); step();
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_4_burst, wb_8_burst, cw_io_oe, cw_ack, cw_err} !== 8'h00)
      begin errors++; $display("FAIL reset_ctl: got %b want 00000000",
                               {wb_cyc, wb_stb, wb_we, wb_4_burst, wb_8_burst, cw_io_oe, cw_ack, cw_err}); end
    checks++;
    if (wb_adr !== 24'h0 || wb_sel !== 2'b00 || wb_o_dat !== 16'h0 || cw_io_o !== 16'h0)
      begin errors++; $display("FAIL reset_data: adr %h sel %b wdat %h rdat %h want zeros",
                               wb_adr, wb_sel, wb_o_dat, cw_io_o); end
    i_rst = 1'b0;
    last_read = 16'h0;
    step();
  endtask

  task automatic test_req_drop();
    cw_dir = 1'b1; cw_req = 1'b1; cw_io_i = 16'h2055;
    step();
    cw_io_i = 16'h7700;
    step();
    checks++;
    if (wb_stb !== 1'b1)
      begin errors++; $display("FAIL req_drop_setup: stb got %b want 1", wb_stb); end
    cw_req = 1'b0;
    step();
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || cw_ack !== 1'b0 || cw_err !== 1'b0)
      begin errors++; $display("FAIL req_drop: cyc%b stb%b ack%b err%b want 0000", wb_cyc, wb_stb, cw_ack, cw_err); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (wb_cyc !== 1'b0 || cw_ack !== 1'b0 || cw_err !== 1'b0)
        begin errors++; $display("FAIL req_drop_after: cyc%b ack%b err%b want 000", wb_cyc, cw_ack, cw_err); end
    end
  endtask

  task automatic test_reset_mid();
    cw_dir = 1'b1; cw_req = 1'b1; cw_io_i = 16'h1812;
    step();
    cw_io_i = 16'h3456;
    step();
    checks++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1)
      begin errors++; $display("FAIL reset_mid_setup: cyc/stb got %b%b want 11", wb_cyc, wb_stb); end
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, cw_io_oe, cw_ack, cw_err} !== 6'b0 || wb_adr !== 24'h0 || cw_io_o !== 16'h0)
      begin errors++; $display("FAIL reset_mid_async: cyc%b stb%b oe%b adr %h rdat %h want zeros",
                               wb_cyc, wb_stb, cw_io_oe, wb_adr, cw_io_o); end
    last_read = 16'h0;
    cw_req = 1'b0;
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cw_ack !== 1'b0 || cw_err !== 1'b0 || wb_cyc !== 1'b0)
        begin errors++; $display("FAIL reset_mid_release: ack%b err%b cyc%b want 000", cw_ack, cw_err, wb_cyc); end
    end
  endtask

  task automatic test_random();
    logic [15:0] h0, h1;
    int          eb;
    for (int t = 0; t < 24; t++) begin
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      if ($urandom_range(3, 0) == 0) begin h0[7:0] = 8'hFF; h1 = 16'hFFFC; end
      eb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      run_txn($sformatf("rand%0d", t), h0, h1, 1'($urandom_range(1, 0)), eb,
              16'($urandom), 16'($urandom), 3);
    end
  endtask

  initial begin
    checks = 0; errors = 0; last_read = 16'h0;
    test_reset();
    run_txn("single_write", 16'h9812, 16'h3456, 1'b0, -1, 16'hBEEF, 16'h0000, 0);
    run_txn("read_burst4", 16'h3800, 16'h0010, 1'b1, -1, 16'h0000, 16'h00A0, 0);
    run_txn("write_burst8_wrap", 16'hD8FF, 16'hFFFE, 1'b0, -1, 16'h1234, 16'h0000, 2);
    run_txn("read_burst4_err", 16'h3800, 16'h0100, 1'b1, 1, 16'h0000, 16'h5500, 1);
    run_txn("both_bursts", 16'h6000, 16'h0000, 1'b1, -1, 16'h0000, 16'h0000, 0);
    test_req_drop();
    test_random();
    test_reset_mid();
    run_txn("after_reset", 16'h1A42, 16'h0001, 1'b1, -1, 16'h0000, 16'hC0DE, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_decompressor.md
WB_DECOMPRESSOR -- requirements
Module: wb_decompressor

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock, shared with the CW bus clock driven by the initiator.
REQ-002 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have CW responder ports:
- cw_io_i, input, 16 bits.
- cw_io_o, output, 16 bits.
- cw_io_oe, output, 1 bit.
- cw_req, input, 1 bit.
- cw_dir, input, 1 bit: 1 = responder drives.
- cw_ack, output, 1 bit.
- cw_err, output, 1 bit.
REQ-004 SHALL have Wishbone master ports:
- wb_cyc, wb_stb, wb_we, output, 1 bit each.
- wb_adr, output, WB_ADDR_W (24) bits.
- wb_sel, output, 2 bits.
- wb_o_dat, output, 16 bits.
- wb_i_dat, input, 16 bits.
- wb_ack, wb_err, input, 1 bit each.
- wb_4_burst, wb_8_burst, output, 1 bit each.

Function
REQ-005 SHALL use FSM states IDLE, ADR, WDAT, BUS, RESP, REL.
REQ-006 In IDLE, cw_req=1 SHALL latch header H0 from cw_io_i:
- [15] we, [14] burst8, [13] burst4, [12:11] sel, [10:8] ignored, [7:0] adr[23:16].
- Next state ADR.
REQ-007 In ADR the FSM SHALL latch adr[15:0] from cw_io_i, then go to WDAT if we=1, else BUS.
REQ-008 WDAT SHALL last one cycle, latch cw_io_i into wb_o_dat, then go to BUS.
REQ-009 Write timing: H0 at cycle T, H1 at T+1, data at T+2, wb_stb first high at T+3.
REQ-010 Read timing: H0 at cycle T, H1 at T+1, wb_stb first high at T+2.
REQ-011 In BUS, wb_cyc=wb_stb=1 with registered adr/we/sel/burst flags SHALL be held until wb_ack or wb_err.
REQ-012 On wb_ack:
- wb_stb=0 next cycle.
- For reads, wb_i_dat registered into cw_io_o.
- cw_ack=1 for exactly one cycle (RESP).
REQ-013 Beat count SHALL be 1, 4 (burst4) or 8 (burst8).
REQ-014 H0 with both burst bits set SHALL pulse cw_err one cycle in ADR's following cycle, issue no Wishbone access, and go to REL.
REQ-015 After RESP with beats remaining:
- wb_adr increments by 1, modulo 2^24 (0xFFFFFF wraps to 0x000000).
- Next state WDAT (write) or BUS (read).
- wb_cyc stays 1 for the whole burst.
REQ-016 After RESP on the last beat, wb_cyc SHALL drop and the FSM SHALL enter REL.
REQ-017 REL SHALL return to IDLE only after sampling cw_req=0; a held cw_req SHALL never be re-decoded as a header.
REQ-018 wb_err in BUS SHALL:
- Drop wb_cyc/wb_stb next cycle.
- Pulse cw_err one cycle; no cw_ack.
- Abort remaining beats and go to REL.
REQ-019 wb_ack and wb_err high together SHALL be treated as wb_err.
REQ-020 cw_req=0 in any state other than IDLE/REL SHALL abort:
- Deassert wb_cyc/wb_stb next cycle.
- No cw_ack/cw_err.
- Go to IDLE.
REQ-021 cw_io_oe SHALL equal cw_dir AND (transaction active AND we=0), registered; otherwise 0.
REQ-022 cw_io_o SHALL hold the last read word until the next read ack.
REQ-023 cw_ack and cw_err SHALL never be high in the same cycle.

Reset
REQ-024 i_rst SHALL force state IDLE and all of the following to 0:
- wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_o_dat, wb_4_burst, wb_8_burst.
- cw_io_o, cw_io_oe, cw_ack, cw_err.
- Beat counter.
REQ-025 Reset asserted mid-transaction SHALL drop wb_cyc immediately (asynchronously), with no cw_ack/cw_err after release.

Structure
REQ-026 The shared config package/header SHALL hold WB_ADDR_W, RW(16), the H0 bit-field positions and the FSM state encoding, for reuse by wb_compressor.
REQ-027 No sub-module; single FSM, 3-bit beat counter, address/data registers.

Verification
REQ-028 Single write, H0=0x9812, H1=0x3456, D=0xBEEF:
- wb_stb at T+3 with adr 0x123456, we=1, sel=2'b11, dat 0xBEEF.
- wb_ack -> one-cycle cw_ack.
REQ-029 Read burst4, H0=0x3800, H1=0x0010, cw_dir=1, slave returns 0xA0..0xA3:
- adr 0x000010..0x000013 under one wb_cyc.
- Four cw_ack pulses with cw_io_o=0xA0..0xA3.
- cw_io_oe=1 throughout.
REQ-030 Write burst8 starting adr 0xFFFFFE:
- Addresses 0xFFFFFE, 0xFFFFFF, 0x000000 .. 0x000005.
- 8 cw_ack pulses, then REL until cw_req=0.
REQ-031 wb_err on beat 2 of a read burst4:
- One cw_err pulse, wb_cyc=0 next cycle.
- No further beats; no new header decode while cw_req stays high.
REQ-032 Abort and reset cases:
- H0=0x6000 (both burst bits set) -> cw_err, zero wb_stb cycles.
- cw_req dropped during BUS -> wb_cyc=0 next cycle.
- i_rst asserted during BUS -> all outputs 0 immediately.
